// File: rtl/demux_dispatch_ctrl.sv
// One-word buffered 1:2 demux controller: valid/ready in, steered valid/ready out.
// Target picked round-robin or by per-word destination; per-output delivery counters.
module demux_dispatch_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dest,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             busy
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_q, sel_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             full, pop, load;

  always_comb begin
    full     = (state_q == StFull);
    pop      = full & (sel_q ? out1_ready : out0_ready);
    in_ready = ~full | pop;
    load     = in_valid & in_ready;

    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    // Pointer advances on delivery only in round-robin mode; a same-cycle load sees the new value.
    rr_ptr_d = (pop & ~mode) ? ~rr_ptr_q : rr_ptr_q;

    unique case (state_q)
      StEmpty: if (load) state_d = StFull;
      StFull:  if (pop && !load) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase

    if (load) begin
      data_d = in_data;
      sel_d  = mode ? in_dest : rr_ptr_d;
    end

    if (pop && !sel_q) cnt0_d = cnt0_q + CNT_W'(1);
    if (pop && sel_q)  cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StEmpty;
      data_q   <= '0;
      sel_q    <= 1'b0;
      rr_ptr_q <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  // The idle output is forced to zero, matching the demux datapath.
  always_comb begin
    out0_valid = full & ~sel_q;
    out1_valid = full & sel_q;
    out0_data  = out0_valid ? data_q : '0;
    out1_data  = out1_valid ? data_q : '0;
    cnt0       = cnt0_q;
    cnt1       = cnt1_q;
    busy       = full;
  end

endmodule
